// File: rtl/kbd_cmd_pkg.sv
// Shared constants for the keyboard command queue: one-hot command codes, port map, IRQ states.
// Status word layout is a packed struct so the port decode and firmware agree on bit positions.
package kbd_cmd_pkg;

  localparam logic [7:0] CMD_UP = 8'h20;
  localparam logic [7:0] CMD_DO = 8'h10;
  localparam logic [7:0] CMD_RI = 8'h08;
  localparam logic [7:0] CMD_LE = 8'h04;
  localparam logic [7:0] CMD_TO = 8'h02;
  localparam logic [7:0] CMD_AS = 8'h01;

  localparam logic [7:0] PORT_KBD_DATA   = 8'h03;
  localparam logic [7:0] PORT_KBD_STATUS = 8'h04;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  typedef struct packed {
    logic       overflow;
    logic       bad_cmd;
    logic [1:0] rsvd;
    logic [3:0] count;
  } status_t;

  function automatic logic is_onehot(input logic [7:0] c);
    return (c != 8'h00) && ((c & (c - 8'd1)) == 8'h00);
  endfunction

endpackage

// File: rtl/cmd_sync_fifo.sv
// Generic synchronous FIFO, head visible combinationally; push to full drops the new entry,
// or with KBD_CMD_DROP_OLDEST_EN overwrites the oldest. ovf pulses on any push into a full FIFO without a pop.
module cmd_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wr_dat,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_pop, wr_en, rd_adv;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign head_dat = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  assign ovf      = push && full && !do_pop;

`ifdef KBD_CMD_DROP_OLDEST_EN
  // Overwrite the oldest slot: read pointer moves with the write so count holds at DEPTH.
  assign wr_en  = push;
  assign rd_adv = do_pop || (push && full);
`else
  assign wr_en  = push && (!full || do_pop);
  assign rd_adv = do_pop;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_adv})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kbd_cmd_fifo.sv
// Queues one-hot keyboard commands for a PicoBlaze-style controller; in_port is 1 cycle after port_id.
// New commands are never back-pressured: a full queue flags overflow (KBD_CMD_DROP_OLDEST_EN selects overwrite).
module kbd_cmd_fifo
  import kbd_cmd_pkg::*;
#(
  parameter int         DEPTH       = 4,
  parameter logic [7:0] PORT_DATA   = PORT_KBD_DATA,
  parameter logic [7:0] PORT_STATUS = PORT_KBD_STATUS
) (
  input  logic       clk,
  input  logic       RST,
  input  logic [7:0] cmd_in,
  input  logic [7:0] port_id,
  input  logic       read_strobe,
  input  logic       interrupt_ack,
  output logic [7:0] in_port,
  output logic       interrupt,
  output logic       src_clr,
  output logic       fifo_empty,
  output logic       fifo_full
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    cmd_q, cmd_prev, head;
  logic [CW-1:0] count;
  logic          new_cmd, push_cand, bad_evt, pop_req, stat_rd, ovf_evt;
  logic          overflow, bad_cmd;
  irq_state_t    state;
  status_t       status;

  // A command is a fresh nonzero value; the translator returns to 0x00 between keys.
  assign new_cmd   = (cmd_q != 8'h00) && (cmd_q != cmd_prev);
  assign push_cand = new_cmd && is_onehot(cmd_q);
  assign bad_evt   = new_cmd && !is_onehot(cmd_q);
  assign pop_req   = read_strobe && (port_id == PORT_DATA);
  assign stat_rd   = read_strobe && (port_id == PORT_STATUS);

  cmd_sync_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk      (clk),
    .RST      (RST),
    .push     (push_cand),
    .pop      (pop_req),
    .wr_dat   (cmd_q),
    .head_dat (head),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .ovf      (ovf_evt)
  );

  always_comb begin
    status          = '0;
    status.overflow = overflow;
    status.bad_cmd  = bad_cmd;
    status.count    = 4'(count);
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cmd_q    <= 8'h00;
      cmd_prev <= 8'h00;
      src_clr  <= 1'b0;
      overflow <= 1'b0;
      bad_cmd  <= 1'b0;
      in_port  <= 8'h00;
    end else begin
      cmd_q    <= cmd_in;
      cmd_prev <= cmd_q;
      src_clr  <= push_cand;
      // A new error event in the clearing cycle keeps its flag set.
      if (ovf_evt)     overflow <= 1'b1;
      else if (stat_rd) overflow <= 1'b0;
      if (bad_evt)     bad_cmd <= 1'b1;
      else if (stat_rd) bad_cmd <= 1'b0;
      if (port_id == PORT_DATA)        in_port <= fifo_empty ? 8'h00 : head;
      else if (port_id == PORT_STATUS) in_port <= status;
      else                             in_port <= 8'h00;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      interrupt <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!fifo_empty) begin
          state     <= REQ;
          interrupt <= 1'b1;
        end
        REQ: if (interrupt_ack) begin
          state     <= SERVICE;
          interrupt <= 1'b0;
        end
        SERVICE: if (fifo_empty) begin
          state     <= IDLE;
          interrupt <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          interrupt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_cmd_fifo.sv
// Bench for kbd_cmd_fifo: directed key/read sequences, with port reads checked by a scoreboard monitor.
module tb_kbd_cmd_fifo;
  import kbd_cmd_pkg::*;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] cmd_in = 8'h00;
  logic [7:0] port_id = 8'h00;
  logic       read_strobe = 1'b0;
  logic       interrupt_ack = 1'b0;
  logic [7:0] in_port;
  logic       interrupt, src_clr, fifo_empty, fifo_full;

  int tests = 0;
  int fails = 0;
  int clr_cnt = 0;
  int c0;
  logic [7:0] exp_val_q[$];
  string      exp_name_q[$];

  always #5 clk = ~clk;

  kbd_cmd_fifo #(.DEPTH(4)) dut (
    .clk           (clk),
    .RST           (RST),
    .cmd_in        (cmd_in),
    .port_id       (port_id),
    .read_strobe   (read_strobe),
    .interrupt_ack (interrupt_ack),
    .in_port       (in_port),
    .interrupt     (interrupt),
    .src_clr       (src_clr),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Monitor: every strobed read presents in_port one edge later; compare with the queued expectation.
  always @(posedge clk) begin : mon
    logic       seen;
    logic [7:0] e;
    string      n;
    seen = read_strobe;
    #1;
    if (src_clr) clr_cnt++;
    if (seen) begin
      if (exp_val_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_read: in_port=%02h with nothing expected", in_port);
      end else begin
        e = exp_val_q.pop_front();
        n = exp_name_q.pop_front();
        check(n, in_port, e);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic key(input logic [7:0] c);
    cmd_in = c;
    tick(2);
    cmd_in = 8'h00;
    tick(2);
  endtask

  task automatic rd(input logic [7:0] p, input logic [7:0] e, input string n);
    port_id     = p;
    read_strobe = 1'b1;
    exp_val_q.push_back(e);
    exp_name_q.push_back(n);
    tick(1);
    read_strobe = 1'b0;
    port_id     = 8'h00;
    tick(1);
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    tick(1);
    interrupt_ack = 1'b0;
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    check("rst_interrupt", 8'(interrupt), 8'h00);
    check("rst_src_clr", 8'(src_clr), 8'h00);
    check("rst_in_port", in_port, 8'h00);
    check("rst_empty", 8'(fifo_empty), 8'h01);
    check("rst_full", 8'(fifo_full), 8'h00);
    RST = 1'b0;
    tick(1);

    // Held key: one push, src_clr one cycle after the push edge
    c0 = clr_cnt;
    cmd_in = CMD_UP;
    tick(1);
    check("t1_clr_early", 8'(src_clr), 8'h00);
    tick(1);
    check("t1_clr_pulse", 8'(src_clr), 8'h01);
    check("t1_not_empty", 8'(fifo_empty), 8'h00);
    tick(1);
    check("t1_clr_end", 8'(src_clr), 8'h00);
    check("t1_irq", 8'(interrupt), 8'h01);
    tick(2);
    cmd_in = 8'h00;
    tick(2);
    check("t1_clr_count", 8'(clr_cnt - c0), 8'd1);
    rd(PORT_KBD_STATUS, 8'h01, "t1_status");
    rd(PORT_KBD_DATA, 8'h20, "t1_data");
    check("t1_empty_after", 8'(fifo_empty), 8'h01);
    ack();
    check("t1_irq_ack", 8'(interrupt), 8'h00);

    // Five commands into a 4-deep queue
    c0 = clr_cnt;
    key(CMD_DO); key(CMD_RI); key(CMD_LE); key(CMD_TO); key(CMD_AS);
    check("t2_full", 8'(fifo_full), 8'h01);
    check("t2_clr_count", 8'(clr_cnt - c0), 8'd5);
    rd(PORT_KBD_STATUS, 8'h84, "t2_status_ovf");
`ifdef KBD_CMD_DROP_OLDEST_EN
    rd(PORT_KBD_DATA, 8'h08, "t2_pop0");
    rd(PORT_KBD_DATA, 8'h04, "t2_pop1");
    rd(PORT_KBD_DATA, 8'h02, "t2_pop2");
    rd(PORT_KBD_DATA, 8'h01, "t2_pop3");
`else
    rd(PORT_KBD_DATA, 8'h10, "t2_pop0");
    rd(PORT_KBD_DATA, 8'h08, "t2_pop1");
    rd(PORT_KBD_DATA, 8'h04, "t2_pop2");
    rd(PORT_KBD_DATA, 8'h02, "t2_pop3");
`endif
    rd(PORT_KBD_DATA, 8'h00, "t2_pop_empty");
    rd(PORT_KBD_STATUS, 8'h00, "t2_status_cleared");
    ack();

    // Non-one-hot command
    c0 = clr_cnt;
    key(8'h21);
    check("t3_no_clr", 8'(clr_cnt - c0), 8'd0);
    check("t3_empty", 8'(fifo_empty), 8'h01);
    rd(PORT_KBD_STATUS, 8'h40, "t3_status_bad");
    rd(PORT_KBD_STATUS, 8'h00, "t3_status_clr");

    // Interrupt handshake
    key(CMD_UP);
    check("t4_irq_req", 8'(interrupt), 8'h01);
    ack();
    check("t4_irq_service", 8'(interrupt), 8'h00);
    key(CMD_DO);
    check("t4_irq_no_reraise", 8'(interrupt), 8'h00);
    rd(PORT_KBD_DATA, 8'h20, "t4_pop0");
    rd(PORT_KBD_DATA, 8'h10, "t4_pop1");
    check("t4_empty", 8'(fifo_empty), 8'h01);
    check("t4_irq_idle", 8'(interrupt), 8'h00);
    key(CMD_RI);
    check("t4_irq_again", 8'(interrupt), 8'h01);
    rd(PORT_KBD_DATA, 8'h08, "t4_pop2");
    ack();

    // Full queue, push and pop on the same edge
    key(CMD_UP); key(CMD_DO); key(CMD_RI); key(CMD_LE);
    check("t5_full", 8'(fifo_full), 8'h01);
    cmd_in = CMD_TO;
    tick(1);
    port_id     = PORT_KBD_DATA;
    read_strobe = 1'b1;
    exp_val_q.push_back(8'h20);
    exp_name_q.push_back("t5_sim_pop");
    tick(1);
    read_strobe = 1'b0;
    port_id     = 8'h00;
    cmd_in      = 8'h00;
    tick(2);
    check("t5_still_full", 8'(fifo_full), 8'h01);
    rd(PORT_KBD_STATUS, 8'h04, "t5_status_no_ovf");
    rd(PORT_KBD_DATA, 8'h10, "t5_pop0");
    rd(PORT_KBD_DATA, 8'h08, "t5_pop1");
    rd(PORT_KBD_DATA, 8'h04, "t5_pop2");
    rd(PORT_KBD_DATA, 8'h02, "t5_pop_tail");
    check("t5_empty", 8'(fifo_empty), 8'h01);

    // Asynchronous reset with three entries queued
    key(CMD_UP); key(CMD_DO); key(CMD_RI);
    port_id = PORT_KBD_STATUS;
    tick(1);
    check("t6_pre_status", in_port, 8'h03);
    check("t6_pre_irq", 8'(interrupt), 8'h01);
    #2;
    RST = 1'b1;
    #1;
    check("t6_rst_irq", 8'(interrupt), 8'h00);
    check("t6_rst_in_port", in_port, 8'h00);
    check("t6_rst_empty", 8'(fifo_empty), 8'h01);
    check("t6_rst_full", 8'(fifo_full), 8'h00);
    @(negedge clk);
    RST = 1'b0;
    port_id = 8'h00;
    tick(1);
    rd(PORT_KBD_DATA, 8'h00, "t6_data_after_rst");
    rd(PORT_KBD_STATUS, 8'h00, "t6_status_after_rst");
    check("t6_irq_idle", 8'(interrupt), 8'h00);

    tick(2);
    check("scoreboard_drained", 8'(exp_val_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
